symbol_slicer_ber: RTL and testbench

Downstream stage of the per-channel moving-average receive filter: takes one channel's filtered signed 24-bit sample stream, counts samples per symbol, and takes a hard bit decision once per symbol period. Decided bits feed a PRBS-7 checker with a hunt/verify/locked state machine and saturating bit and error counters for on-board BER measurement. Instantiate once per audio channel (left, right).

---
 rtl/symbol_slicer_ber.sv | 188 ++++++++++++++++++
 tb/tb_symbol_slicer_ber.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_slicer_ber.sv
// Symbol slicer and PRBS-7 bit-error-rate checker for one receive channel.
// Counts samples per symbol, takes a hard sign decision at a fixed phase, and
// checks the decided bits against a self-synchronising PRBS-7 reference.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_HUNT   | collecting 7 decided bits to seed the reference generator
// ST_VERIFY | checking one window; any error drops back to ST_HUNT
// ST_LOCKED | counting bits/errors; LOSS_THRESH errors in a window unlock
module symbol_slicer_ber #(
   parameter int SPS          = 64,
   parameter int SAMPLE_PHASE = 63,
   parameter int LOCK_WIN     = 64,
   parameter int LOSS_THRESH  = 16,
   parameter int CNT_W        = 32
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic                    sample_valid,
   input  logic signed [23:0]      din,
   input  logic                    clear_counts,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic                    locked,
   output logic [CNT_W-1:0]        bit_count,
   output logic [CNT_W-1:0]        err_count
);

   localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
   localparam int WMAX  = (LOCK_WIN > LOSS_THRESH) ? LOCK_WIN : LOSS_THRESH;
   localparam int WIN_W = $clog2(WMAX + 1);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);
   localparam logic [PH_W-1:0]  PH_DEC   = PH_W'(SAMPLE_PHASE);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(LOCK_WIN - 1);
   localparam logic [WIN_W-1:0] LOSS_N   = WIN_W'(LOSS_THRESH);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   logic [PH_W-1:0]  phase_q, phase_d;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   state_t           state_q, state_d;
   logic [6:0]       lfsr_q, lfsr_d;
   logic [6:0]       fill_q, fill_d;
   logic [2:0]       fill_cnt_q, fill_cnt_d;
   logic [WIN_W-1:0] win_bits_q, win_bits_d;
   logic [WIN_W-1:0] win_errs_q, win_errs_d;
   logic [CNT_W-1:0] bit_count_q, bit_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic             exp_bit;
   logic             mismatch;
   logic [WIN_W-1:0] win_errs_nxt;
   logic             win_end;

   // Reference bit comes from the local generator, never from the received bit,
   // so a single channel error does not propagate into later comparisons.
   assign exp_bit      = lfsr_q[6] ^ lfsr_q[5];
   assign mismatch     = bit_out_q ^ exp_bit;
   assign win_errs_nxt = win_errs_q + {{(WIN_W-1){1'b0}}, mismatch};
   assign win_end      = (win_bits_q == WIN_LAST);

   // Symbol phase counter and hard decision (zero decides as 1).
   always_comb begin
      phase_d     = phase_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
      if (sample_valid) begin
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
         if (phase_q == PH_DEC) begin
            bit_out_d   = (din >= 24'sd0);
            bit_valid_d = 1'b1;
         end
      end
   end

   // Checker next-state: hunt/verify/locked sequencing and saturating counters.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      fill_d      = fill_q;
      fill_cnt_d  = fill_cnt_q;
      win_bits_d  = win_bits_q;
      win_errs_d  = win_errs_q;
      bit_count_d = bit_count_q;
      err_count_d = err_count_q;

      if (bit_valid_q) begin
         case (state_q)
            ST_HUNT: begin
               fill_d = {fill_q[5:0], bit_out_q};
               if (fill_cnt_q == 3'd6) begin
                  fill_cnt_d = '0;
                  // An all-zero seed would lock the generator at zero forever.
                  if (fill_d != 7'd0) begin
                     lfsr_d     = fill_d;
                     win_bits_d = '0;
                     win_errs_d = '0;
                     state_d    = ST_VERIFY;
                  end
               end else begin
                  fill_cnt_d = fill_cnt_q + 3'd1;
               end
            end
            ST_VERIFY: begin
               lfsr_d = {lfsr_q[5:0], exp_bit};
               if (win_end) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
                  fill_cnt_d = '0;
                  state_d    = (win_errs_nxt == '0) ? ST_LOCKED : ST_HUNT;
               end else begin
                  win_bits_d = win_bits_q + 1'b1;
                  win_errs_d = win_errs_nxt;
               end
            end
            ST_LOCKED: begin
               lfsr_d = {lfsr_q[5:0], exp_bit};
               if (bit_count_q != '1) bit_count_d = bit_count_q + 1'b1;
               if (mismatch && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
               if (win_errs_nxt >= LOSS_N) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
                  fill_cnt_d = '0;
                  state_d    = ST_HUNT;
               end else if (win_end) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
               end else begin
                  win_bits_d = win_bits_q + 1'b1;
                  win_errs_d = win_errs_nxt;
               end
            end
            default: begin
               fill_cnt_d = '0;
               state_d    = ST_HUNT;
            end
         endcase
      end

      // Clear wins over a bit checked in the same cycle.
      if (clear_counts) begin
         bit_count_d = '0;
         err_count_d = '0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         phase_q     <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         state_q     <= ST_HUNT;
         lfsr_q      <= '0;
         fill_q      <= '0;
         fill_cnt_q  <= '0;
         win_bits_q  <= '0;
         win_errs_q  <= '0;
         bit_count_q <= '0;
         err_count_q <= '0;
      end else begin
         phase_q     <= phase_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         fill_q      <= fill_d;
         fill_cnt_q  <= fill_cnt_d;
         win_bits_q  <= win_bits_d;
         win_errs_q  <= win_errs_d;
         bit_count_q <= bit_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
   assign locked    = (state_q == ST_LOCKED);
   assign bit_count = bit_count_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_symbol_slicer_ber.sv
// Bench for symbol_slicer_ber: SPS=4, SAMPLE_PHASE=3, LOCK_WIN=8, LOSS_THRESH=3,
// 4-bit counters so saturation is reachable in a short run.
module tb_symbol_slicer_ber;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              sample_valid = 1'b0;
   logic signed [23:0] din = '0;
   logic              clear_counts = 1'b0;
   logic              bit_out, bit_valid, locked;
   logic [3:0]        bit_count, err_count;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   tb_phase = 0;
   int   n_bv = 0;
   logic exp_q[$];
   bit   prbs[64];

   always #5 clk = ~clk;

   symbol_slicer_ber #(
      .SPS(4), .SAMPLE_PHASE(3), .LOCK_WIN(8), .LOSS_THRESH(3), .CNT_W(4)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .sample_valid(sample_valid), .din(din),
      .clear_counts(clear_counts), .bit_out(bit_out), .bit_valid(bit_valid),
      .locked(locked), .bit_count(bit_count), .err_count(err_count)
   );

   // One clock: drive inputs, push expected decision, check the strobe/bit after the edge.
   task automatic cyc(input logic sv, input logic signed [23:0] d, input logic clr);
      logic exp_bv;
      logic eb;
      sample_valid = sv;
      din          = d;
      clear_counts = clr;
      exp_bv       = 1'b0;
      if (sv) begin
         if (tb_phase == 3) begin
            exp_q.push_back(d >= 0);
            exp_bv = 1'b1;
         end
         tb_phase = (tb_phase + 1) % 4;
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      clear_counts = 1'b0;
      n_tests++;
      if (bit_valid !== exp_bv) begin
         n_fail++;
         $display("FAIL bit_valid_strobe: got %b want %b at %0t", bit_valid, exp_bv, $time);
      end
      if (bit_valid === 1'b1) begin
         n_bv++;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL bit_out_unexpected: got %b want no decision at %0t", bit_out, $time);
         end else begin
            eb = exp_q.pop_front();
            if (bit_out !== eb) begin
               n_fail++;
               $display("FAIL bit_out_value: got %b want %b at %0t", bit_out, eb, $time);
            end
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample_valid = 1'b0;
      clear_counts = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      tb_phase = 0;
      exp_q.delete();
   endtask

   // Four samples of one symbol; returns in the cycle where bit_valid is high.
   task automatic sym_dec(input bit b);
      for (int i = 0; i < 4; i++) cyc(1'b1, b ? 24'sd1000 : -24'sd1000, 1'b0);
   endtask

   // Full symbol; returns once the checker has registered the bit.
   task automatic sym(input bit b);
      sym_dec(b);
      cyc(1'b0, 24'sd0, 1'b0);
   endtask

   task automatic lock_up();
      for (int i = 0; i < 15; i++) sym(prbs[i]);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests += 5;
      if (bit_out !== 1'b0)   begin n_fail++; $display("FAIL reset_bit_out: got %b want 0", bit_out); end
      if (bit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bit_valid: got %b want 0", bit_valid); end
      if (locked !== 1'b0)    begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
      if (bit_count !== 4'h0) begin n_fail++; $display("FAIL reset_bit_count: got %h want 0", bit_count); end
      if (err_count !== 4'h0) begin n_fail++; $display("FAIL reset_err_count: got %h want 0", err_count); end
   endtask

   task automatic test_decision();
      int vals[8] = '{-5, -5, -5, 7, 0, 0, 0, 0};
      int bv0;
      do_reset();
      bv0 = n_bv;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 24'(vals[i]), 1'b0);
         cyc(1'b0, 24'sd0, 1'b0);
         cyc(1'b0, 24'sd0, 1'b0);
      end
      for (int i = 0; i < 4; i++) cyc(1'b1, -24'sd1, 1'b0);
      cyc(1'b0, 24'sd0, 1'b0);
      n_tests += 3;
      if (n_bv - bv0 !== 3) begin n_fail++; $display("FAIL decision_count: got %0d want 3", n_bv - bv0); end
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL decision_pending: got %0d want 0", exp_q.size()); end
      if (bit_out !== 1'b0) begin n_fail++; $display("FAIL decision_last_bit: got %b want 0", bit_out); end
   endtask

   task automatic test_lock();
      do_reset();
      for (int i = 0; i < 14; i++) begin
         sym(prbs[i]);
         n_tests++;
         if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b want 0 after bit %0d", locked, i); end
      end
      sym_dec(prbs[14]);
      n_tests++;
      if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_at_strobe: got %b want 0", locked); end
      cyc(1'b0, 24'sd0, 1'b0);
      n_tests += 3;
      if (locked !== 1'b1)    begin n_fail++; $display("FAIL lock_rise: got %b want 1", locked); end
      if (bit_count !== 4'h0) begin n_fail++; $display("FAIL lock_bit_count: got %h want 0", bit_count); end
      if (err_count !== 4'h0) begin n_fail++; $display("FAIL lock_err_count: got %h want 0", err_count); end
      for (int k = 1; k <= 5; k++) begin
         sym(prbs[14 + k]);
         n_tests += 3;
         if (bit_count !== 4'(k)) begin n_fail++; $display("FAIL lock_bit_inc: got %h want %h", bit_count, 4'(k)); end
         if (err_count !== 4'h0)  begin n_fail++; $display("FAIL lock_no_err: got %h want 0", err_count); end
         if (locked !== 1'b1)     begin n_fail++; $display("FAIL lock_hold: got %b want 1", locked); end
      end
   endtask

   task automatic test_loss();
      do_reset();
      lock_up();
      for (int i = 15; i < 23; i++) begin
         sym((i == 17 || i == 20) ? ~prbs[i] : prbs[i]);
         n_tests++;
         if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_two_errs_locked: got %b want 1 at bit %0d", locked, i); end
      end
      n_tests += 2;
      if (err_count !== 4'd2) begin n_fail++; $display("FAIL loss_two_errs_count: got %h want 2", err_count); end
      if (bit_count !== 4'd8) begin n_fail++; $display("FAIL loss_two_errs_bits: got %h want 8", bit_count); end
      for (int i = 23; i < 26; i++) begin
         sym((i == 25) ? prbs[i] : ~prbs[i]);
         n_tests++;
         if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_early: got %b want 1 at bit %0d", locked, i); end
      end
      sym_dec(~prbs[26]);
      n_tests++;
      if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_at_strobe: got %b want 1", locked); end
      cyc(1'b0, 24'sd0, 1'b0);
      n_tests += 3;
      if (locked !== 1'b0)     begin n_fail++; $display("FAIL loss_fall: got %b want 0", locked); end
      if (err_count !== 4'd5)  begin n_fail++; $display("FAIL loss_err_count: got %h want 5", err_count); end
      if (bit_count !== 4'd12) begin n_fail++; $display("FAIL loss_bit_count: got %h want c", bit_count); end
   endtask

   task automatic test_verify_fail();
      do_reset();
      for (int i = 0; i < 7; i++) sym(1'b0);
      for (int i = 0; i < 14; i++) begin
         sym(prbs[i]);
         n_tests++;
         if (locked !== 1'b0) begin n_fail++; $display("FAIL zero_fill_early: got %b want 0 at bit %0d", locked, i); end
      end
      sym(prbs[14]);
      n_tests++;
      if (locked !== 1'b1) begin n_fail++; $display("FAIL zero_fill_relock: got %b want 1", locked); end

      do_reset();
      for (int i = 0; i < 15; i++) begin
         sym((i == 10) ? ~prbs[i] : prbs[i]);
         n_tests++;
         if (locked !== 1'b0) begin n_fail++; $display("FAIL verify_err_locked: got %b want 0 at bit %0d", locked, i); end
      end
      n_tests += 2;
      if (bit_count !== 4'h0) begin n_fail++; $display("FAIL verify_err_bits: got %h want 0", bit_count); end
      if (err_count !== 4'h0) begin n_fail++; $display("FAIL verify_err_errs: got %h want 0", err_count); end
      for (int i = 15; i < 29; i++) begin
         sym(prbs[i]);
         n_tests++;
         if (locked !== 1'b0) begin n_fail++; $display("FAIL rehunt_early: got %b want 0 at bit %0d", locked, i); end
      end
      sym(prbs[29]);
      n_tests++;
      if (locked !== 1'b1) begin n_fail++; $display("FAIL rehunt_lock: got %b want 1", locked); end
   endtask

   task automatic test_counters();
      int want;
      do_reset();
      lock_up();
      sym(prbs[15]);
      sym(~prbs[16]);
      sym(prbs[17]);
      n_tests += 2;
      if (bit_count !== 4'd3) begin n_fail++; $display("FAIL cnt_pre_bits: got %h want 3", bit_count); end
      if (err_count !== 4'd1) begin n_fail++; $display("FAIL cnt_pre_errs: got %h want 1", err_count); end
      sym_dec(prbs[18]);
      cyc(1'b0, 24'sd0, 1'b1);
      n_tests += 2;
      if (bit_count !== 4'd0) begin n_fail++; $display("FAIL clear_bits: got %h want 0", bit_count); end
      if (err_count !== 4'd0) begin n_fail++; $display("FAIL clear_errs: got %h want 0", err_count); end
      for (int k = 1; k <= 17; k++) begin
         sym(prbs[18 + k]);
         want = (k > 15) ? 15 : k;
         n_tests += 2;
         if (bit_count !== 4'(want)) begin n_fail++; $display("FAIL sat_bits: got %h want %h", bit_count, 4'(want)); end
         if (err_count !== 4'd0)     begin n_fail++; $display("FAIL sat_errs: got %h want 0", err_count); end
      end
   endtask

   task automatic test_reset_mid();
      int bv0;
      do_reset();
      lock_up();
      sym(prbs[15]);
      sym(prbs[16]);
      n_tests++;
      if (bit_count !== 4'd2) begin n_fail++; $display("FAIL mid_pre_bits: got %h want 2", bit_count); end
      cyc(1'b1, 24'sd1000, 1'b0);
      cyc(1'b1, 24'sd1000, 1'b0);
      do_reset();
      n_tests += 5;
      if (bit_out !== 1'b0)   begin n_fail++; $display("FAIL mid_bit_out: got %b want 0", bit_out); end
      if (bit_valid !== 1'b0) begin n_fail++; $display("FAIL mid_bit_valid: got %b want 0", bit_valid); end
      if (locked !== 1'b0)    begin n_fail++; $display("FAIL mid_locked: got %b want 0", locked); end
      if (bit_count !== 4'h0) begin n_fail++; $display("FAIL mid_bit_count: got %h want 0", bit_count); end
      if (err_count !== 4'h0) begin n_fail++; $display("FAIL mid_err_count: got %h want 0", err_count); end
      bv0 = n_bv;
      for (int i = 0; i < 3; i++) cyc(1'b1, -24'sd1000, 1'b0);
      n_tests++;
      if (n_bv - bv0 !== 0) begin n_fail++; $display("FAIL mid_early_strobe: got %0d want 0", n_bv - bv0); end
      cyc(1'b1, -24'sd1000, 1'b0);
      n_tests++;
      if (n_bv - bv0 !== 1) begin n_fail++; $display("FAIL mid_first_strobe: got %0d want 1", n_bv - bv0); end
      cyc(1'b0, 24'sd0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) prbs[i] = (i < 7) ? 1'b1 : (prbs[i-7] ^ prbs[i-6]);
      test_reset();
      test_decision();
      test_lock();
      test_loss();
      test_verify_fail();
      test_counters();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
